matrix_frame_scanner: RTL and testbench
=======================================

# matrix_frame_scanner

Double-buffered frame store and column-scan driver for the 8x8 RGB LED matrix. Game logic writes a complete frame into the back bank column by column, then requests a swap. The scanner continuously reads the front bank and drives the active-low `DATA_R/G/B` and the `COMM` column select. This replaces ad-hoc drawing inside the refresh loop, so the display never shows a half-drawn frame.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: CLK cycles per column. Must be ≥ 2, and ≥ `BLANK_CYC`+1 when blanking is compiled in.
- `BLANK_CYC`, default 4: leading blank cycles per column. Used only with `MATRIX_BLANK_EN`.

Ports:
- `CLK` in, 1: system clock.
- `ResetN` in, 1: asynchronous, active-low reset.
- `wr_en` in, 1: write strobe into the back bank.
- `wr_col` in, 3: column index of the write.
- `wr_r`, `wr_g`, `wr_b` in, 8 each: column pixel data. Bit n is row n; 1 = lit.
- `swap_req` in, 1: request a front/back exchange at the next frame boundary.
- `swap_ack` out, 1: one-cycle pulse on the cycle the banks exchange.
- `frame_start` out, 1: one-cycle pulse when the column wraps 7→0.
- `DATA_R`, `DATA_G`, `DATA_B` out, 8 each: row drive, active-low (0 = lit).
- `COMM` out, 3: active column index.
- `enable` out, 1: matrix driver enable.

## Operation

- **Storage:** two banks, each 8 columns × 24 bits. The `bank_sel` bit selects the front bank; the other bank is the back bank.
- **Writes:**
  - When `wr_en`=1, `{wr_r,wr_g,wr_b}` is written to `back[wr_col]` on the rising edge.
  - Writes never touch the front bank.
  - After a swap, the new back bank holds the previously displayed frame. There is no copy and no clear.
- **Scan:**
  - `div_cnt` counts 0..`SCAN_DIV`-1.
  - At terminal count, `div_cnt` returns to 0 and `col` increments mod 8.
- **Registered outputs:**
  - `COMM` = `col`.
  - `DATA_x` = ~`front[col]` (per colour).
  - Both update on the same edge as `col`.
- **Swap state machine:**
  - IDLE: `swap_req`=1 → PEND.
  - PEND: at the 7→0 column wrap, toggle `bank_sel`, pulse `swap_ack` → IDLE.
  - A `swap_req` asserted while in PEND, or in the `swap_ack` cycle, is absorbed and not queued.
- **Reset values:**
  - Both banks all-zero (dark).
  - `bank_sel`=0, `col`=0, `div_cnt`=0, state IDLE.
  - `COMM`=0, `DATA_R/G/B`=8'hFF, `swap_ack`=0, `frame_start`=0, `enable`=0.
  - `enable` becomes 1 on the first CLK edge after `ResetN` deasserts and stays 1.

## Timing

- The column period is exactly `SCAN_DIV` CLK cycles. The frame period is 8×`SCAN_DIV`.
- `frame_start`, `swap_ack` and the bank toggle occur on the same edge that sets `COMM` 7→0. On that edge, `DATA_x` already reflects the new front bank's column 0.
- **Swap latency:** from `swap_req` to `swap_ack` is 1 cycle minimum (request on the cycle before the wrap) and 8×`SCAN_DIV` cycles maximum.
- **Write in the swap cycle:** a write on the same edge as the swap lands in the pre-swap back bank, so it is visible in the new frame.
- **Write to the displayed column:** not possible, because writes target the back bank only.
- **Reset mid-frame:** all state returns to reset values asynchronously. A pending swap is discarded.
- `wr_col` wraps naturally; its 3-bit width covers all columns. There are no out-of-range cases.

## Configuration

- `MATRIX_BLANK_EN` defined:
  - For `div_cnt` < `BLANK_CYC` of every column, `DATA_R/G/B` = 8'hFF (anti-ghosting). Front-bank data is driven afterwards.
  - `COMM` still changes at the column boundary.
- `MATRIX_BLANK_EN` undefined:
  - No blanking; `DATA_x` is valid for the full column period.
  - `BLANK_CYC` is ignored.

## Test plan

Use `SCAN_DIV`=4 and `BLANK_CYC`=1 for all scenarios.

- **Reset values:** assert `ResetN`=0 mid-scan → `COMM`=0, `DATA_R/G/B`=8'hFF, `enable`=0, `swap_ack`=0 immediately; `enable`=1 one edge after release.
- **Write then swap:** write col3 `wr_r`=8'h81, then `swap_req` → after `swap_ack`, with `COMM`=3: `DATA_R`=8'h7E, `DATA_G`=`DATA_B`=8'hFF. The other columns show all 8'hFF.
- **No swap, no display:** write all columns 8'hFF with no `swap_req` for 3 frames → `DATA_x` stays 8'hFF.
- **Swap deferred to boundary:** `swap_req` pulsed when `COMM`=2 → `swap_ack` coincides with `COMM` 7→0 and `frame_start` (latency 22 cycles from mid-col-2 start). A second `swap_req` while pending yields exactly one `swap_ack`.
- **Write in swap cycle:** write col0 `wr_g`=8'h01 on the `swap_ack` edge → `DATA_G`=8'hFE when `COMM`=0 in the new frame.
- **Blanking:** with `MATRIX_BLANK_EN`, a lit pixel reads 8'hFF for the first cycle of its column and the lit value for the remaining 3 cycles. Without the macro, the lit value holds for all 4 cycles.

Source files
------------

// File: rtl/matrix_frame_scanner.sv
// rtl/matrix_frame_scanner.sv - double-buffered 8x8 RGB frame store with column-scan driver
// Optional leading per-column blanking is compiled in with `define MATRIX_BLANK_EN.
module matrix_frame_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       CLK,
  input  logic       ResetN,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic [2:0] COMM,
  output logic       enable
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
`ifdef MATRIX_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t                state_q, state_d;
  logic [1:0][7:0][23:0] mem_q, mem_d;
  logic                  bank_sel_q, bank_sel_d;
  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [2:0]            col_q, col_d;
  logic [23:0]           data_q, data_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  frame_start_q, frame_start_d;
  logic                  enable_q;
  logic                  wrap;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= S_IDLE;
      mem_q         <= '0;
      bank_sel_q    <= 1'b0;
      div_cnt_q     <= '0;
      col_q         <= 3'd0;
      data_q        <= '1;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      enable_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      bank_sel_q    <= bank_sel_d;
      div_cnt_q     <= div_cnt_d;
      col_q         <= col_d;
      data_q        <= data_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      enable_q      <= 1'b1;
    end
  end

  always_comb begin
    div_cnt_d     = div_cnt_q + 1'b1;
    col_d         = col_q;
    wrap          = 1'b0;
    mem_d         = mem_q;
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    swap_ack_d    = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      col_d     = col_q + 3'd1;
      wrap      = (col_q == 3'd7);
    end

    // Write uses the pre-swap back bank, so a write on the swap edge shows in the new frame.
    if (wr_en) mem_d[~bank_sel_q][wr_col] = {wr_r, wr_g, wr_b};

    // A request arriving while pending or during the ack cycle is dropped, not queued.
    case (state_q)
      S_IDLE: if (swap_req && !swap_ack_q) state_d = S_PEND;
      S_PEND: begin
        if (wrap) begin
          state_d    = S_IDLE;
          bank_sel_d = ~bank_sel_q;
          swap_ack_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    frame_start_d = wrap;
    data_d        = ~mem_d[bank_sel_d][col_d];
    if (BLANK_EN && (int'(div_cnt_d) < BLANK_CYC)) data_d = '1;
  end

  assign COMM        = col_q;
  assign DATA_R      = data_q[23:16];
  assign DATA_G      = data_q[15:8];
  assign DATA_B      = data_q[7:0];
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign enable      = enable_q;

endmodule

// File: tb/tb_matrix_frame_scanner.sv
// tb/tb_matrix_frame_scanner.sv - self-checking bench for matrix_frame_scanner (SCAN_DIV=4, BLANK_CYC=1)
module tb_matrix_frame_scanner;

  localparam int SD = 4;
  localparam int BC = 1;
`ifdef MATRIX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       ResetN = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_col = 3'd0;
  logic [7:0] wr_r = 8'h00, wr_g = 8'h00, wr_b = 8'h00;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start, enable;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [2:0] COMM;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  matrix_frame_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLK(CLK), .ResetN(ResetN), .wr_en(wr_en), .wr_col(wr_col),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .swap_req(swap_req),
    .swap_ack(swap_ack), .frame_start(frame_start),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .COMM(COMM), .enable(enable)
  );

  // Reference model: n = edges since reset release, column/phase derived arithmetically.
  logic [23:0] bank [2][8] = '{default: 24'h0};
  int  sel = 0;
  int  n = 0;
  bit  pend = 0, ack_e = 0, fs_e = 0;

  always @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++) bank[b][c] = 24'h0;
      sel = 0; n = 0; pend = 0; ack_e = 0; fs_e = 0;
    end else begin
      bit wrp, old_pend, old_ack;
      n++;
      wrp      = (n % (8 * SD) == 0);
      old_pend = pend;
      old_ack  = ack_e;
      if (wr_en) bank[1 - sel][wr_col] = {wr_r, wr_g, wr_b};
      fs_e  = wrp;
      ack_e = old_pend && wrp;
      if (ack_e) sel = 1 - sel;
      pend = (old_pend && !wrp) || (!old_pend && swap_req && !old_ack);
    end
  end

  function automatic logic [29:0] model_out();
    int col, div;
    logic [23:0] d;
    col = (n / SD) % 8;
    div = n % SD;
    d = ~bank[sel][col];
    if (BLANK && div < BC) d = 24'hFFFFFF;
    return {3'(col), d, ack_e, fs_e, (n >= 1)};
  endfunction

  always @(negedge CLK) begin
    logic [29:0] act, exp_v;
    act   = {COMM, DATA_R, DATA_G, DATA_B, swap_ack, frame_start, enable};
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL outputs t=%0t got=%h want=%h", $time, act, exp_v);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic reset_dut();
    @(negedge CLK); #2 ResetN = 1'b0;
    @(negedge CLK); #2 ResetN = 1'b1;
  endtask

  task automatic wait_comm(input logic [2:0] c, input string nm);
    int k = 0;
    while (COMM !== c && k < 100) begin
      @(negedge CLK); k++;
    end
    check(nm, {29'd0, COMM}, {29'd0, c});
  endtask

  task automatic write_col(input logic [2:0] c, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    wr_en = 1'b1; wr_col = c; wr_r = r; wr_g = g; wr_b = b;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  initial begin
    int bad, lat, acks, k;

    #1 ResetN = 1'b0;
    repeat (2) @(negedge CLK);
    ResetN = 1'b1;

    // Reset values: asynchronous assertion mid-scan.
    repeat (10) @(negedge CLK);
    #2 ResetN = 1'b0;
    #1;
    check("rst_comm", {29'd0, COMM}, 32'd0);
    check("rst_data", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h00FFFFFF);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_ack", {31'd0, swap_ack}, 32'd0);
    @(negedge CLK); #2 ResetN = 1'b1;
    @(posedge CLK); #1;
    check("enable_after_release", {31'd0, enable}, 32'd1);

    // No swap, no display: back bank filled but never shown.
    reset_dut();
    for (int c = 0; c < 8; c++) write_col(3'(c), 8'hFF, 8'hFF, 8'hFF);
    bad = 0;
    for (int i = 0; i < 3 * 8 * SD; i++) begin
      @(negedge CLK);
      if ({DATA_R, DATA_G, DATA_B} !== 24'hFFFFFF) bad++;
    end
    check("noswap_dark", bad, 0);

    // Write then swap.
    reset_dut();
    write_col(3'd3, 8'h81, 8'h00, 8'h00);
    swap_req = 1'b1; @(negedge CLK); swap_req = 1'b0;
    k = 0;
    while (swap_ack !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
    check("ws_ack_seen", {31'd0, swap_ack}, 32'd1);
    wait_comm(3'd3, "ws_comm3");
    check("ws_first_cycle_r", {24'd0, DATA_R}, BLANK ? 32'hFF : 32'h7E);
    @(negedge CLK);
    check("ws_r", {24'd0, DATA_R}, 32'h7E);
    check("ws_gb", {16'd0, DATA_G, DATA_B}, 32'hFFFF);

    // Swap deferred to the frame boundary, second request absorbed.
    reset_dut();
    wait_comm(3'd2, "def_comm2");
    @(negedge CLK);
    swap_req = 1'b1;
    lat = 0; acks = 0;
    while (swap_ack !== 1'b1 && lat < 100) begin
      @(negedge CLK); lat++;
      swap_req = (lat == 5);
    end
    swap_req = 1'b0;
    check("def_latency", lat - 1, 22);
    check("def_comm0", {29'd0, COMM}, 32'd0);
    check("def_frame_start", {31'd0, frame_start}, 32'd1);
    acks = 1;
    for (int i = 0; i < 2 * 8 * SD; i++) begin
      @(negedge CLK);
      if (swap_ack === 1'b1) acks++;
    end
    check("def_single_ack", acks, 1);

    // Write landing on the swap edge.
    swap_req = 1'b1; @(negedge CLK); swap_req = 1'b0;
    wait_comm(3'd7, "wsc_comm7");
    repeat (3) @(negedge CLK);
    write_col(3'd0, 8'h00, 8'h01, 8'h00);
    check("wsc_ack", {31'd0, swap_ack}, 32'd1);
    check("wsc_comm0", {29'd0, COMM}, 32'd0);
    check("wsc_first_g", {24'd0, DATA_G}, BLANK ? 32'hFF : 32'hFE);
    @(negedge CLK);
    check("wsc_g", {24'd0, DATA_G}, 32'hFE);
    check("wsc_rb", {16'd0, DATA_R, DATA_B}, 32'hFFFF);
    repeat (8 * SD) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
